rv_div_dispatch: RTL

RV_DIV_DISPATCH -- requirements
Module: RV_div_dispatch

---
 rtl/rv_div_dispatch_pkg.sv | 33 +++
 rtl/rv_serial_div.sv | 119 +++++++++++
 rtl/rv_div_dispatch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv_div_dispatch_pkg.sv
// rtl/rv_div_dispatch_pkg.sv - shared divide op encodings and FSM state encodings
package rv_div_dispatch_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dispatch_state_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_PREP = 2'd1,
    DV_BUSY = 2'd2,
    DV_DONE = 2'd3
  } div_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rv_serial_div.sv
// rtl/rv_serial_div.sv - multi-lane restoring divider returning magnitude quotient/remainder
module rv_serial_div
  import rv_div_dispatch_pkg::*;
#(
  parameter int WIDTHN = 32,
  parameter int WIDTHD = 32,
  parameter int WIDTHQ = 32,
  parameter int WIDTHR = 32,
  parameter int LANES  = 1,
  parameter int TAGW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    signed_mode,
  input  logic [LANES*WIDTHN-1:0] dividend,
  input  logic [LANES*WIDTHD-1:0] divisor,
  input  logic [TAGW-1:0]         tag_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [LANES*WIDTHQ-1:0] quotient,
  output logic [LANES*WIDTHR-1:0] remainder,
  output logic [TAGW-1:0]         tag_out
);

  localparam int CW = $clog2(WIDTHN + 1);

  div_state_e                     state_q, state_d;
  logic                           sgn_q, sgn_d;
  logic [TAGW-1:0]                tag_q, tag_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [LANES-1:0][WIDTHN-1:0]   num_q, num_d;
  logic [LANES-1:0][WIDTHD-1:0]   den_q, den_d;
  logic [LANES-1:0][WIDTHD-1:0]   rem_q, rem_d;
  logic [LANES-1:0][WIDTHD:0]     shift_w;
  logic [LANES-1:0][WIDTHD+1:0]   diff_w;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      shift_w[l] = {rem_q[l], num_q[l][WIDTHN-1]};
      diff_w[l]  = {1'b0, shift_w[l]} - {2'b00, den_q[l]};
    end
  end

  // num_q holds the raw dividend, then its magnitude, then shifts into the quotient.
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    case (state_q)
      DV_IDLE: if (valid_in) begin
        num_d   = dividend;
        den_d   = divisor;
        sgn_d   = signed_mode;
        tag_d   = tag_in;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = DV_PREP;
      end
      DV_PREP: begin
        for (int l = 0; l < LANES; l++) begin
          num_d[l] = (sgn_q && num_q[l][WIDTHN-1]) ? -num_q[l] : num_q[l];
          den_d[l] = (sgn_q && den_q[l][WIDTHD-1]) ? -den_q[l] : den_q[l];
        end
        state_d = DV_BUSY;
      end
      DV_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          if (!diff_w[l][WIDTHD+1]) begin
            rem_d[l] = diff_w[l][WIDTHD-1:0];
            num_d[l] = {num_q[l][WIDTHN-2:0], 1'b1};
          end else begin
            rem_d[l] = shift_w[l][WIDTHD-1:0];
            num_d[l] = {num_q[l][WIDTHN-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTHN - 1)) state_d = DV_DONE;
      end
      DV_DONE: if (ready_out) state_d = DV_IDLE;
      default: state_d = DV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DV_IDLE;
      sgn_q   <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
    end
  end

  assign ready_in  = (state_q == DV_IDLE);
  assign valid_out = (state_q == DV_DONE);
  assign tag_out   = tag_q;

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign quotient[l*WIDTHQ +: WIDTHQ]  = num_q[l][WIDTHQ-1:0];
    assign remainder[l*WIDTHR +: WIDTHR] = rem_q[l][WIDTHR-1:0];
  end

endmodule

// File: rtl/rv_div_dispatch.sv
// rtl/rv_div_dispatch.sv - single-request RISC-V divide dispatcher around a serial divider
module rv_div_dispatch
  import rv_div_dispatch_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAGW  = 1,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [1:0]             op_type,
  input  logic [LANES*WIDTH-1:0] alu_in1,
  input  logic [LANES*WIDTH-1:0] alu_in2,
  input  logic [TAGW-1:0]        tag_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [LANES*WIDTH-1:0] result,
  output logic [TAGW-1:0]        tag_out
);

  dispatch_state_e              state_q, state_d;
  div_op_e                      op_q, op_d;
  logic [LANES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [TAGW-1:0]              tag_q, tag_d, tag_out_q, tag_out_d;
  logic [LANES*WIDTH-1:0]       result_q, result_d;
  logic                         ready_in_q, ready_in_d, valid_out_q, valid_out_d;

  logic                         div_valid_in, div_ready_in, div_valid_out, div_ready_out;
  logic [LANES*WIDTH-1:0]       div_quo, div_rem;
  logic [1:0]                   div_tag;
  div_op_e                      resp_op;
  logic [WIDTH-1:0]             lane_res [LANES];

  assign div_valid_in  = (state_q == ST_ISSUE);
  assign div_ready_out = (state_q == ST_WAIT) && div_valid_out;
  assign resp_op       = div_op_e'(div_tag);

  rv_serial_div #(
    .WIDTHN(WIDTH), .WIDTHD(WIDTH), .WIDTHQ(WIDTH), .WIDTHR(WIDTH),
    .LANES(LANES), .TAGW(2)
  ) u_div (
    .clk        (clk),
    .rst        (~reset),
    .valid_in   (div_valid_in),
    .ready_in   (div_ready_in),
    .signed_mode(is_signed_op(op_q)),
    .dividend   (a_q),
    .divisor    (b_q),
    .tag_in     (op_q),
    .valid_out  (div_valid_out),
    .ready_out  (div_ready_out),
    .quotient   (div_quo),
    .remainder  (div_rem),
    .tag_out    (div_tag)
  );

  // The divider works on magnitudes; signs and the RISC-V special cases are restored here.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] a, b, qm, rm, q_fix, r_fix;
    logic             sgn, rem_sel, div0, ovf;
    assign a       = a_q[l];
    assign b       = b_q[l];
    assign qm      = div_quo[l*WIDTH +: WIDTH];
    assign rm      = div_rem[l*WIDTH +: WIDTH];
    assign sgn     = is_signed_op(resp_op);
    assign rem_sel = is_rem_op(resp_op);
    assign div0    = (b == '0);
    assign ovf     = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign q_fix   = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -qm : qm;
    assign r_fix   = (sgn && a[WIDTH-1]) ? -rm : rm;
    assign lane_res[l] = div0 ? (rem_sel ? a : '1)
                       : ovf  ? (rem_sel ? '0 : a)
                       :        (rem_sel ? r_fix : q_fix);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    case (state_q)
      ST_IDLE: if (valid_in) begin
        op_d    = div_op_e'(op_type);
        a_d     = alu_in1;
        b_d     = alu_in2;
        tag_d   = tag_in;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (div_ready_in) state_d = ST_WAIT;
      ST_WAIT: if (div_valid_out) begin
        for (int l = 0; l < LANES; l++) result_d[l*WIDTH +: WIDTH] = lane_res[l];
        tag_out_d = tag_q;
        state_d   = ST_RESP;
      end
      ST_RESP: if (ready_out) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_in_d  = (state_d == ST_IDLE);
    valid_out_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_DIV;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      tag_out_q   <= '0;
      ready_in_q  <= 1'b1;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      tag_out_q   <= tag_out_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign ready_in  = ready_in_q;
  assign valid_out = valid_out_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule
